multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Sequencing controller for the multicycle variant of the MIPS core. One shared unified memory, one ALU and one
//  register file are reused across FETCH/DECODE/EXECUTE/MEM/WB steps. The block drives every datapath mux and
//  write enable from a Moore state machine. The memory side uses a req/ready handshake guarded by a watchdog.
// PARAMETERS
//  MEM_HANDSHAKE  1    1: memory states wait for mem_ready; 0: mem_ready is treated as constant 1
//  TIMEOUT_CYCLES 255  max wait cycles in any memory state before abort (8-bit counter, 1..255)
// PORTS
//  clk          in   1  rising-edge clock
//  rst_n        in   1  asynchronous active-low reset
//  opcode       in   6  instr[31:26] from the instruction register
//  mem_ready    in   1  memory completes the current access this cycle
//  mem_req      out  1  memory access request
//  i_or_d       out  1  memory address select: 0=PC, 1=ALUOut
//  mem_write    out  1  store enable; qualified by mem_ready
//  ir_write     out  1  instruction register load
//  pc_write     out  1  unconditional PC load
//  branch       out  1  PC load if ALU zero
//  pc_src       out  2  00=ALU result, 01=ALUOut, 10=jump target
//  alu_src_a    out  1  0=PC, 1=rd1
//  alu_src_b    out  2  00=rd2, 01=const 4, 10=signImm, 11=signImm<<2
//  alu_op       out  2  00=add, 01=sub, 10=funct-decoded
//  reg_dst      out  1  1=rd (instr[15:11]), 0=rt
//  mem_to_reg   out  1  1=memory data, 0=ALUOut
//  reg_write    out  1  register file write enable
//  illegal_op   out  1  1-cycle pulse on an unsupported opcode in DECODE
//  mem_timeout  out  1  1-cycle pulse on watchdog abort
//  state        out  4  current state (debug)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 ALUWB=7 BRANCH=8 ADDIEX=9 ADDIWB=10 JUMP=11
//  Reset: state=FETCH. All outputs are 0 while rst_n=0. After release, outputs follow the state decode.
//  Reset mid-instruction aborts the instruction immediately. Nothing in flight is committed.
//  FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
//   ir_write=pc_write=mem_ready, so the PC and IR update only on the handshake cycle. Go to DECODE when mem_ready=1.
//  DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target). Next state by opcode:
//   100011(lw)/101011(sw)->MEMADR, 000000(R)->EXEC, 000100(beq)->BRANCH, 001000(addi)->ADDIEX, 000010(j)->JUMP.
//   Any other opcode -> FETCH with illegal_op=1 for that cycle.
//  MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next MEMRD if lw, else MEMWR.
//  MEMRD: mem_req=1, i_or_d=1. Go to MEMWB on mem_ready.
//  MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next FETCH.
//  MEMWR: mem_req=1, i_or_d=1, mem_write=mem_ready. Go to FETCH on mem_ready.
//  EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next ALUWB.
//  ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, branch=1, pc_src=01. Next FETCH.
//  ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next ADDIWB.
//  ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
//  JUMP: pc_write=1, pc_src=10. Next FETCH.
//  Unlisted outputs are 0 in each state.
//  Watchdog: 8-bit wait_cnt clears on entry to FETCH/MEMRD/MEMWR and increments each cycle there with mem_ready=0.
//   When wait_cnt reaches TIMEOUT_CYCLES with mem_ready still 0: pulse mem_timeout, go to FETCH, PC not updated.
//   mem_ready=1 in the same cycle as the timeout wins: normal handshake, no timeout pulse.
//  mem_ready seen outside memory states is ignored. Unreachable state codes 12..15 -> FETCH next cycle.
//  CPI with zero-wait memory: lw=5, sw=4, R=4, addi=4, beq=3, j=3.
// TESTING
//  rst_n low mid-EXEC, release -> state=0, all outputs 0 during reset; first FETCH has mem_req=1.
//  lw (100011), mem_ready always 1 -> states 0,1,2,3,4,0; reg_write=1 only in MEMWB with mem_to_reg=1.
//  sw, mem_ready held low 3 cycles in MEMWR -> stays in 5; mem_write=1 for exactly 1 cycle.
//  beq/j/addi/R sequences -> per-state decode matches table; beq 3 cycles, R 4 cycles.
//  opcode 111111 in DECODE -> illegal_op pulse, next state FETCH, reg_write never asserted.
//  TIMEOUT_CYCLES=4, mem_ready=0 in FETCH -> mem_timeout pulse after 4 waits, pc_write never asserted, re-enter FETCH.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS sequencing controller: Moore state decode drives every datapath
// mux and write enable; memory states use a req/ready handshake with a wait watchdog.
module multicycle_control_fsm #(
  parameter bit          MEM_HANDSHAKE  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       i_or_d,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  localparam int unsigned CNT_W = 8;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_ADDIEX = 4'd9,
    ST_ADDIWB = 4'd10,
    ST_JUMP   = 4'd11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_cnt_nxt;

  logic       w_ready;
  logic       w_mem_state;
  logic       w_timeout;

  logic       w_mem_req;
  logic       w_i_or_d;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_branch;
  logic [1:0] w_pc_src;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_reg_write;
  logic       w_illegal_op;

  assign w_ready     = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign w_mem_state = (r_state == ST_FETCH) || (r_state == ST_MEMRD) || (r_state == ST_MEMWR);
  // Ready in the abort cycle wins, so the watchdog only fires while ready is still low.
  assign w_timeout   = w_mem_state && !w_ready && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES));

  // State and wait-counter registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_FETCH;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Next-state selection plus Moore control decode for the current state.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = '0;
    w_mem_req      = 1'b0;
    w_i_or_d       = 1'b0;
    w_mem_write    = 1'b0;
    w_ir_write     = 1'b0;
    w_pc_write     = 1'b0;
    w_branch       = 1'b0;
    w_pc_src       = 2'b00;
    w_alu_src_a    = 1'b0;
    w_alu_src_b    = 2'b00;
    w_alu_op       = 2'b00;
    w_reg_dst      = 1'b0;
    w_mem_to_reg   = 1'b0;
    w_reg_write    = 1'b0;
    w_illegal_op   = 1'b0;

    // Count only while parked in a memory state; any transition or re-entry clears it.
    if (w_mem_state && !w_ready && !w_timeout) begin
      w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
    end

    case (r_state)
      ST_FETCH: begin
        w_mem_req   = 1'b1;
        w_alu_src_b = 2'b01;
        w_ir_write  = w_ready;
        w_pc_write  = w_ready;
        if (w_ready) w_state_nxt = ST_DECODE;
        else         w_state_nxt = ST_FETCH;
      end
      ST_DECODE: begin
        w_alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: w_state_nxt = ST_MEMADR;
          OP_R:         w_state_nxt = ST_EXEC;
          OP_BEQ:       w_state_nxt = ST_BRANCH;
          OP_ADDI:      w_state_nxt = ST_ADDIEX;
          OP_J:         w_state_nxt = ST_JUMP;
          default: begin
            w_state_nxt  = ST_FETCH;
            w_illegal_op = 1'b1;
          end
        endcase
      end
      ST_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_state_nxt = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        w_mem_req = 1'b1;
        w_i_or_d  = 1'b1;
        if (w_ready)        w_state_nxt = ST_MEMWB;
        else if (w_timeout) w_state_nxt = ST_FETCH;
      end
      ST_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_state_nxt  = ST_FETCH;
      end
      ST_MEMWR: begin
        w_mem_req   = 1'b1;
        w_i_or_d    = 1'b1;
        w_mem_write = w_ready;
        if (w_ready || w_timeout) w_state_nxt = ST_FETCH;
      end
      ST_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
        w_state_nxt = ST_ALUWB;
      end
      ST_ALUWB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
        w_state_nxt = ST_FETCH;
      end
      ST_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b01;
        w_branch    = 1'b1;
        w_pc_src    = 2'b01;
        w_state_nxt = ST_FETCH;
      end
      ST_ADDIEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_state_nxt = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        w_reg_write = 1'b1;
        w_state_nxt = ST_FETCH;
      end
      ST_JUMP: begin
        w_pc_write  = 1'b1;
        w_pc_src    = 2'b10;
        w_state_nxt = ST_FETCH;
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  // Every output is forced low while reset is asserted.
  assign mem_req     = rst_n & w_mem_req;
  assign i_or_d      = rst_n & w_i_or_d;
  assign mem_write   = rst_n & w_mem_write;
  assign ir_write    = rst_n & w_ir_write;
  assign pc_write    = rst_n & w_pc_write;
  assign branch      = rst_n & w_branch;
  assign pc_src      = rst_n ? w_pc_src    : 2'b00;
  assign alu_src_a   = rst_n & w_alu_src_a;
  assign alu_src_b   = rst_n ? w_alu_src_b : 2'b00;
  assign alu_op      = rst_n ? w_alu_op    : 2'b00;
  assign reg_dst     = rst_n & w_reg_dst;
  assign mem_to_reg  = rst_n & w_mem_to_reg;
  assign reg_write   = rst_n & w_reg_write;
  assign illegal_op  = rst_n & w_illegal_op;
  assign mem_timeout = rst_n & w_timeout;
  assign state       = rst_n ? r_state     : 4'd0;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: an instruction-level model expands each instruction into its
// expected per-cycle control vector; a negedge monitor pops and compares.
module tb_multicycle_control_fsm;

  localparam int unsigned T = 4;

  localparam int S_FETCH  = 0;
  localparam int S_DECODE = 1;
  localparam int S_MEMADR = 2;
  localparam int S_MEMRD  = 3;
  localparam int S_MEMWB  = 4;
  localparam int S_MEMWR  = 5;
  localparam int S_EXEC   = 6;
  localparam int S_ALUWB  = 7;
  localparam int S_BRANCH = 8;
  localparam int S_ADDIEX = 9;
  localparam int S_ADDIWB = 10;
  localparam int S_JUMP   = 11;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
    logic       mem_timeout;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_req, i_or_d, mem_write, ir_write, pc_write, branch;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op, mem_timeout;
  logic [3:0] state;

  exp_t exp_q[$];
  exp_t mon_e, mon_g;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_no  = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(
    .MEM_HANDSHAKE (1'b1),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .i_or_d     (i_or_d),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .branch     (branch),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .illegal_op (illegal_op),
    .mem_timeout(mem_timeout),
    .state      (state)
  );

  // Monitor: compare the DUT's control vector against the oldest expectation.
  always @(negedge clk) begin
    cyc_no <= cyc_no + 1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_g = {state, mem_req, i_or_d, mem_write, ir_write, pc_write, branch, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
               illegal_op, mem_timeout};
      n_tests++;
      if (mon_g !== mon_e) begin
        n_fail++;
        $display("FAIL ctrl_vec cycle %0d: got state=%0d vec=%h, expected state=%0d vec=%h",
                 cyc_no, mon_g.st, mon_g, mon_e.st, mon_e);
      end
    end
  end

  // Control table for one step, written from the per-state description.
  function automatic exp_t mk(input int st, input logic rdy, input logic ill, input logic tmo);
    exp_t e;
    e    = '0;
    e.st = 4'(st);
    case (st)
      S_FETCH:  begin e.mem_req = 1'b1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; e.mem_timeout = tmo; end
      S_DECODE: begin e.alu_src_b = 2'b11; e.illegal_op = ill; end
      S_MEMADR: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      S_MEMRD:  begin e.mem_req = 1'b1; e.i_or_d = 1'b1; e.mem_timeout = tmo; end
      S_MEMWB:  begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
      S_MEMWR:  begin e.mem_req = 1'b1; e.i_or_d = 1'b1; e.mem_write = rdy; e.mem_timeout = tmo; end
      S_EXEC:   begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
      S_ALUWB:  begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
      S_BRANCH: begin e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.branch = 1'b1; e.pc_src = 2'b01; end
      S_ADDIEX: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      S_ADDIWB: begin e.reg_write = 1'b1; end
      S_JUMP:   begin e.pc_write = 1'b1; e.pc_src = 2'b10; end
      default:  e = '0;
    endcase
    return e;
  endfunction

  function automatic logic rr();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock: drive inputs, queue the expected response, advance to just past the edge.
  task automatic cyc(input logic [5:0] op, input logic rdy, input exp_t e);
    opcode    = op;
    mem_ready = rdy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // A memory step with w wait cycles: handshake if w <= T, else T waits plus an abort cycle.
  task automatic mem_phase(input int st, input int w, input logic [5:0] op, output bit ok);
    if (w > int'(T)) begin
      for (int i = 0; i < int'(T); i++) cyc(op, 1'b0, mk(st, 1'b0, 1'b0, 1'b0));
      cyc(op, 1'b0, mk(st, 1'b0, 1'b0, 1'b1));
      ok = 1'b0;
    end else begin
      for (int i = 0; i < w; i++) cyc(op, 1'b0, mk(st, 1'b0, 1'b0, 1'b0));
      cyc(op, 1'b1, mk(st, 1'b1, 1'b0, 1'b0));
      ok = 1'b1;
    end
  endtask

  // Instruction-level model: fetch (retried after abort), then the opcode's step list.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    bit ok;
    mem_phase(S_FETCH, fw, 6'($urandom), ok);
    while (!ok) mem_phase(S_FETCH, int'($urandom_range(0, T)), 6'($urandom), ok);
    case (op)
      OP_LW: begin
        cyc(op, rr(), mk(S_DECODE, 1'b0, 1'b0, 1'b0));
        cyc(op, rr(), mk(S_MEMADR, 1'b0, 1'b0, 1'b0));
        mem_phase(S_MEMRD, mw, op, ok);
        if (ok) cyc(op, rr(), mk(S_MEMWB, 1'b0, 1'b0, 1'b0));
      end
      OP_SW: begin
        cyc(op, rr(), mk(S_DECODE, 1'b0, 1'b0, 1'b0));
        cyc(op, rr(), mk(S_MEMADR, 1'b0, 1'b0, 1'b0));
        mem_phase(S_MEMWR, mw, op, ok);
      end
      OP_R: begin
        cyc(op, rr(), mk(S_DECODE, 1'b0, 1'b0, 1'b0));
        cyc(op, rr(), mk(S_EXEC, 1'b0, 1'b0, 1'b0));
        cyc(op, rr(), mk(S_ALUWB, 1'b0, 1'b0, 1'b0));
      end
      OP_BEQ: begin
        cyc(op, rr(), mk(S_DECODE, 1'b0, 1'b0, 1'b0));
        cyc(op, rr(), mk(S_BRANCH, 1'b0, 1'b0, 1'b0));
      end
      OP_ADDI: begin
        cyc(op, rr(), mk(S_DECODE, 1'b0, 1'b0, 1'b0));
        cyc(op, rr(), mk(S_ADDIEX, 1'b0, 1'b0, 1'b0));
        cyc(op, rr(), mk(S_ADDIWB, 1'b0, 1'b0, 1'b0));
      end
      OP_J: begin
        cyc(op, rr(), mk(S_DECODE, 1'b0, 1'b0, 1'b0));
        cyc(op, rr(), mk(S_JUMP, 1'b0, 1'b0, 1'b0));
      end
      default: cyc(op, rr(), mk(S_DECODE, 1'b0, 1'b1, 1'b0));
    endcase
  endtask

  // Hold reset for n cycles with mem_ready high; every output must stay zero.
  task automatic hold_reset(input int n);
    exp_t z;
    z     = '0;
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) cyc(6'($urandom), 1'b1, z);
    rst_n = 1'b1;
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] legal [6];
    logic [5:0] o;
    legal = '{OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
    if ($urandom_range(0, 9) < 8) return legal[$urandom_range(0, 5)];
    o = 6'h3f;
    for (int k = 0; k < 10; k++) begin
      o = 6'($urandom);
      if (!(o inside {OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW})) return o;
    end
    return 6'h3f;
  endfunction

  initial begin
    rst_n     = 1'b0;
    opcode    = '0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    hold_reset(3);

    // Directed sequences.
    run_instr(OP_LW,   0, 0);
    run_instr(OP_SW,   0, 3);
    run_instr(OP_BEQ,  0, 0);
    run_instr(OP_J,    0, 0);
    run_instr(OP_ADDI, 0, 0);
    run_instr(OP_R,    0, 0);
    run_instr(6'h3f,   0, 0);
    run_instr(OP_R,    T + 1, 0);
    run_instr(OP_J,    T, 0);
    run_instr(OP_LW,   0, T);
    run_instr(OP_LW,   0, T + 1);
    run_instr(OP_SW,   0, T + 2);

    // Reset asserted in the middle of an EXEC cycle.
    cyc(6'($urandom), 1'b1, mk(S_FETCH, 1'b1, 1'b0, 1'b0));
    cyc(OP_R, rr(), mk(S_DECODE, 1'b0, 1'b0, 1'b0));
    opcode    = OP_R;
    mem_ready = rr();
    exp_q.push_back(mk(S_EXEC, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    #1;
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    hold_reset(2);
    run_instr(OP_ADDI, 0, 0);

    // Randomized instruction stream with random memory latencies.
    for (int n = 0; n < 300; n++) begin
      run_instr(pick_op(), int'($urandom_range(0, T + 1)), int'($urandom_range(0, T + 2)));
    end

    @(posedge clk);
    @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
